// File: rtl/i2s_rx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : i2s_rx_ctrl_if
// Brief    : Serial-in / sample-out bundle for the I2S receive sequencer.
//            err_cnt is present only when I2S_RX_ERR_CNT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
interface i2s_rx_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  en;
  logic                  ws;
  logic                  sdin;
  logic [DATA_WIDTH-1:0] data;
  logic                  l_vld;
  logic                  r_vld;
  logic                  busy;
  logic                  frame_err;
`ifdef I2S_RX_ERR_CNT_EN
  logic [15:0]           err_cnt;

  modport master (
    output en, ws, sdin,
    input  data, l_vld, r_vld, busy, frame_err, err_cnt
  );
  modport slave (
    input  en, ws, sdin,
    output data, l_vld, r_vld, busy, frame_err, err_cnt
  );
`else
  modport master (
    output en, ws, sdin,
    input  data, l_vld, r_vld, busy, frame_err
  );
  modport slave (
    input  en, ws, sdin,
    output data, l_vld, r_vld, busy, frame_err
  );
`endif
endinterface
`default_nettype wire

// File: rtl/i2s_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : i2s_rx_ctrl
// Brief    : I2S receive sequencer, one-bit-delayed MSB-first deserialiser with
//            per-channel strobes. Optional frame-error counter: I2S_RX_ERR_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module i2s_rx_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter bit WS_LEFT_LEVEL = 1'b0
) (
  input  logic         sck,
  input  logic         rst_n,
  i2s_rx_ctrl_if.slave bus
);
  localparam int               CNT_W      = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SHIFT = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t                state_q,     state_d;
  logic                  ws_d_q,      ws_d_d;
  logic [CNT_W-1:0]      bit_cnt_q,   bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q,     shift_d;
  logic [DATA_WIDTH-1:0] data_q,      data_d;
  logic                  ch_left_q,   ch_left_d;
  logic                  l_vld_q,     l_vld_d;
  logic                  r_vld_q,     r_vld_d;
  logic                  busy_q,      busy_d;
  logic                  frame_err_q, frame_err_d;
`ifdef I2S_RX_ERR_CNT_EN
  logic [15:0]           err_cnt_q,   err_cnt_d;
`endif

  logic                  w_ws_edge;
  logic                  w_ws_left;
  logic                  w_last_bit;
  logic [DATA_WIDTH-1:0] w_shift_in;

  always_comb begin
    w_ws_edge  = (bus.ws != ws_d_q);
    w_ws_left  = (bus.ws == WS_LEFT_LEVEL);
    w_last_bit = (bit_cnt_q == c_last_bit);
    w_shift_in = {shift_q[DATA_WIDTH-2:0], bus.sdin};

    state_d     = state_q;
    ws_d_d      = bus.ws;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    ch_left_d   = ch_left_q;
    l_vld_d     = 1'b0;
    r_vld_d     = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        if (bus.en) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!bus.en) begin
          state_d = S_IDLE;
        end else if (w_ws_edge) begin
          state_d   = S_SHIFT;
          bit_cnt_d = '0;
          ch_left_d = w_ws_left;
        end
      end
      S_SHIFT: begin
        if (w_last_bit) begin
          // Last bit wins over en-drop and over a coinciding next-slot edge.
          shift_d = w_shift_in;
          data_d  = w_shift_in;
          l_vld_d = ch_left_q;
          r_vld_d = !ch_left_q;
          if (!bus.en) begin
            state_d = S_IDLE;
          end else if (w_ws_edge) begin
            state_d   = S_SHIFT;
            bit_cnt_d = '0;
            ch_left_d = w_ws_left;
          end else begin
            state_d = S_HOLD;
          end
        end else if (!bus.en) begin
          state_d = S_IDLE;
        end else if (w_ws_edge) begin
          frame_err_d = 1'b1;
          bit_cnt_d   = '0;
          ch_left_d   = w_ws_left;
        end else begin
          shift_d   = w_shift_in;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (!bus.en) begin
          state_d = S_IDLE;
        end else if (w_ws_edge) begin
          state_d   = S_SHIFT;
          bit_cnt_d = '0;
          ch_left_d = w_ws_left;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_SHIFT);

`ifdef I2S_RX_ERR_CNT_EN
    err_cnt_d = err_cnt_q;
    if (!bus.en) begin
      err_cnt_d = '0;
    end else if (frame_err_d && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
`endif
  end

  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ws_d_q      <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      ch_left_q   <= 1'b0;
      l_vld_q     <= 1'b0;
      r_vld_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef I2S_RX_ERR_CNT_EN
      err_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ws_d_q      <= ws_d_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      ch_left_q   <= ch_left_d;
      l_vld_q     <= l_vld_d;
      r_vld_q     <= r_vld_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
`ifdef I2S_RX_ERR_CNT_EN
      err_cnt_q   <= err_cnt_d;
`endif
    end
  end

  assign bus.data      = data_q;
  assign bus.l_vld     = l_vld_q;
  assign bus.r_vld     = r_vld_q;
  assign bus.busy      = busy_q;
  assign bus.frame_err = frame_err_q;
`ifdef I2S_RX_ERR_CNT_EN
  assign bus.err_cnt   = err_cnt_q;
`endif

endmodule
`default_nettype wire
